// File: rtl/mmio_pkg.sv
// Shared MMIO definitions for the button/texture block.
// Holds the register offsets relative to BASE_ADDR.
package mmio_pkg;

  typedef enum logic [1:0] {
    REG_STATUS  = 2'd0,
    REG_PENDING = 2'd1,
    REG_TEXTURE = 2'd2
  } reg_off_e;

  localparam int NUM_REGS = 3;

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, debouncer, press detect.
// Ports: clk, reset, i_btn (raw), o_level (debounced), o_press (0->1 pulse).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int CW =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_level_q;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        // This edge is the DEBOUNCE_CYCLES-th differing sample.
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_level & ~r_level_q;

endmodule

// File: rtl/button_mmio.sv
// Memory-mapped push-button block: STATUS, W1C PENDING, TEXTURE.
// Ports: clk, reset, addr/mwe/data/ram_q/data_out (CPU), btn, texture_idx, btn_pending.
module button_mmio
  import mmio_pkg::*;
#(
  parameter int          NUM_BTN         = 4,
  parameter int          DEBOUNCE_CYCLES = 250000,
  parameter int          NUM_TEXTURES    = 16,
  parameter int          TEX_W           = 4,
  parameter logic [11:0] BASE_ADDR       = 12'hFF0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        addr,
  input  logic               mwe,
  input  logic [31:0]        data,
  input  logic [31:0]        ram_q,
  output logic [31:0]        data_out,
  input  logic [NUM_BTN-1:0] btn,
  output logic [TEX_W-1:0]   texture_idx,
  output logic [NUM_BTN-1:0] btn_pending
);

  localparam logic [TEX_W:0] NT = (TEX_W + 1)'(NUM_TEXTURES);
  localparam logic [TEX_W-1:0] TMAX = TEX_W'(NUM_TEXTURES - 1);

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_press;
  logic [NUM_BTN:0]   w_press_x;
  logic [NUM_BTN-1:0] w_clr;
  logic [11:0]        w_off;
  logic               w_hit;
  logic               w_sel_st;
  logic               w_sel_pd;
  logic               w_sel_tx;
  logic               w_inc;
  logic               w_dec;
  logic [TEX_W:0]     w_wr_mod;
  logic [TEX_W-1:0]   w_tex_inc;
  logic [TEX_W-1:0]   w_tex_dec;
  logic               w_unused;

  logic [NUM_BTN-1:0] r_pend;
  logic [TEX_W-1:0]   r_tex;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .i_btn  (btn[gi]),
      .o_level(w_level[gi]),
      .o_press(w_press[gi])
    );
  end

  assign w_off    = addr - BASE_ADDR;
  assign w_hit    = (w_off < 12'(NUM_REGS));
  assign w_sel_st = w_hit && (w_off[1:0] == REG_STATUS);
  assign w_sel_pd = w_hit && (w_off[1:0] == REG_PENDING);
  assign w_sel_tx = w_hit && (w_off[1:0] == REG_TEXTURE);

  // Zero pad so a single-button build sees no decrement event.
  assign w_press_x = {1'b0, w_press};
  assign w_inc     = w_press_x[0];
  assign w_dec     = w_press_x[1];

  assign w_clr = (mwe && w_sel_pd) ? data[NUM_BTN-1:0] : '0;

  assign w_wr_mod  = {1'b0, data[TEX_W-1:0]} % NT;
  assign w_tex_inc = (r_tex == TMAX) ? '0 : r_tex + 1'b1;
  assign w_tex_dec = (r_tex == '0) ? TMAX : r_tex - 1'b1;

  assign w_unused = ^{data, w_wr_mod, w_press_x};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_tex  <= '0;
    end else begin
      // Set is ORed after the clear so a same-edge press wins.
      r_pend <= (r_pend & ~w_clr) | w_press;
      if (mwe && w_sel_tx) begin
        r_tex <= w_wr_mod[TEX_W-1:0];
      end else if (w_inc && !w_dec) begin
        r_tex <= w_tex_inc;
      end else if (w_dec && !w_inc) begin
        r_tex <= w_tex_dec;
      end
    end
  end

  always_comb begin
    data_out = ram_q;
    unique case (1'b1)
      w_sel_st: data_out = 32'(w_level);
      w_sel_pd: data_out = 32'(r_pend);
      w_sel_tx: data_out = 32'(r_tex);
      default:  data_out = ram_q;
    endcase
  end

  assign btn_pending = r_pend;
  assign texture_idx = r_tex;

endmodule
